// File: rtl/addsub_accum_pkg.sv
// rtl/addsub_accum_pkg.sv - shared opcodes, FSM encodings and default width for the accumulator
package addsub_accum_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

endpackage

// File: rtl/addsub_core.sv
// rtl/addsub_core.sv - combinational ripple-carry adder-subtractor with carry and signed overflow
module addsub_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ctrl_i,
    output logic [WIDTH-1:0] s_o,
    output logic             co_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   c;

    // Subtraction is A + ~B + 1: invert B and inject the +1 as carry-in
    assign bx   = b_i ^ {WIDTH{ctrl_i}};
    assign c[0] = ctrl_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ bx[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & bx[i]) | (c[i] & (a_i[i] ^ bx[i]));
    end

    assign co_o  = c[WIDTH];
    assign ovf_o = (a_i[WIDTH-1] == bx[WIDTH-1]) && (s_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/addsub_accum.sv
// rtl/addsub_accum.sv - handshaked accumulate unit: accept op/b, execute once, hold result until consumed
module addsub_accum
    import addsub_accum_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             co,
    output logic             zero,
    output logic             ovf
);

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             co_q, co_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;

    logic [WIDTH-1:0] core_s;
    logic             core_co;
    logic             core_ovf;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a_i    (acc_q),
        .b_i    (b_q),
        .ctrl_i (op_q[0]),
        .s_o    (core_s),
        .co_o   (core_co),
        .ovf_o  (core_ovf)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        b_d     = b_q;
        acc_d   = acc_q;
        co_d    = co_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && ready_q) begin
                    op_d    = op;
                    b_d     = b;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        acc_d = core_s;
                        co_d  = core_co;
                        ovf_d = core_ovf;
                    end
                    OP_LOAD: begin
                        acc_d = b_q;
                        co_d  = 1'b0;
                        ovf_d = 1'b0;
                    end
                    default: begin
                        acc_d = '0;
                        co_d  = 1'b0;
                        ovf_d = 1'b0;
                    end
                endcase
                zero_d  = (acc_d == '0);
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered ready keeps in_ready low through reset and the first edge after it
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            co_q    <= 1'b0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            co_q    <= co_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q == ST_HOLD);
    assign acc       = acc_q;
    assign co        = co_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_addsub_accum.sv
// tb/tb_addsub_accum.sv - directed self-checking bench for addsub_accum
module tb_addsub_accum;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] acc;
    logic       co;
    logic       zero;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    addsub_accum #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .co        (co),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [3:0] e_acc, input logic e_co,
                                input logic e_zero, input logic e_ovf);
        check({tag, ".acc"},  {28'd0, acc},  {28'd0, e_acc});
        check({tag, ".co"},   {31'd0, co},   {31'd0, e_co});
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, e_zero});
        check({tag, ".ovf"},  {31'd0, ovf},  {31'd0, e_ovf});
    endtask

    // One full transaction with fixed latency: accept, EXEC, HOLD, consume
    task automatic run_op(input string tag, input logic [1:0] o, input logic [3:0] v,
                          input logic [3:0] e_acc, input logic e_co, input logic e_zero,
                          input logic e_ovf);
        check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op       = o;
        b        = v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".exec_in_ready"},  {31'd0, in_ready},  32'd0);
        check({tag, ".exec_out_valid"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        check_result(tag, e_acc, e_co, e_zero, e_ovf);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".idle_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".idle_in_ready"},  {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'b00;
        b         = 4'd0;
        out_ready = 1'b0;

        @(negedge clk);
        check("rst.in_ready",  {31'd0, in_ready},  32'd0);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check_result("rst", 4'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel.in_ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("rel.in_ready_after_edge", {31'd0, in_ready}, 32'd1);

        run_op("load2",  2'b10, 4'd2,  4'd2,  1'b0, 1'b0, 1'b0);
        run_op("add4",   2'b00, 4'd4,  4'd6,  1'b0, 1'b0, 1'b0);
        run_op("load9",  2'b10, 4'd9,  4'd9,  1'b0, 1'b0, 1'b0);
        run_op("add14",  2'b00, 4'd14, 4'd7,  1'b1, 1'b0, 1'b1);
        run_op("load12", 2'b10, 4'd12, 4'd12, 1'b0, 1'b0, 1'b0);
        run_op("sub9",   2'b01, 4'd9,  4'd3,  1'b1, 1'b0, 1'b0);
        run_op("load9b", 2'b10, 4'd9,  4'd9,  1'b0, 1'b0, 1'b0);
        run_op("sub12",  2'b01, 4'd12, 4'd13, 1'b0, 1'b0, 1'b0);
        run_op("load7",  2'b10, 4'd7,  4'd7,  1'b0, 1'b0, 1'b0);
        run_op("add1",   2'b00, 4'd1,  4'd8,  1'b0, 1'b0, 1'b1);
        run_op("load5",  2'b10, 4'd5,  4'd5,  1'b0, 1'b0, 1'b0);
        run_op("sub5",   2'b01, 4'd5,  4'd0,  1'b1, 1'b1, 1'b0);
        run_op("load3",  2'b10, 4'd3,  4'd3,  1'b0, 1'b0, 1'b0);
        run_op("add15",  2'b00, 4'd15, 4'd2,  1'b1, 1'b0, 1'b0);
        run_op("clr",    2'b11, 4'd9,  4'd0,  1'b0, 1'b1, 1'b0);

        // out_ready while idle must not disturb anything
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_ordy.in_ready",  {31'd0, in_ready},  32'd1);
        check("idle_ordy.out_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: result held for 5 cycles while a new request is offered
        in_valid = 1'b1;
        op       = 2'b10;
        b        = 4'd3;
        @(posedge clk);
        @(negedge clk);
        op = 2'b00;
        b  = 4'd1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp.out_valid", {31'd0, out_valid}, 32'd1);
            check("bp.in_ready",  {31'd0, in_ready},  32'd0);
            check_result("bp", 4'd3, 1'b0, 1'b0, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_rel.in_ready",  {31'd0, in_ready},  32'd1);
        check("bp_rel.out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_rel.acc",       {28'd0, acc},       32'd3);

        // Reset during EXEC discards the pending ADD
        run_op("load2r", 2'b10, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0);
        run_op("add4r",  2'b00, 4'd4, 4'd6, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        op       = 2'b00;
        b        = 4'd4;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rexec.in_ready",  {31'd0, in_ready},  32'd0);
        check("rexec.out_valid", {31'd0, out_valid}, 32'd0);
        check_result("rexec", 4'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("rexec_hold.out_valid", {31'd0, out_valid}, 32'd0);
        check("rexec_hold.acc",       {28'd0, acc},       32'd0);
        rst_n = 1'b1;
        #1;
        check("rexec_rel.in_ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("rexec_rel.in_ready", {31'd0, in_ready}, 32'd1);
        check_result("rexec_rel", 4'd0, 1'b0, 1'b1, 1'b0);

        run_op("post_add5", 2'b00, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
